srl_fifo_fwft_gen2: RTL and testbench
=====================================

Name: srl_fifo_fwft_gen2

Overview:
Parametrised successor to the shift-register storage used under the start/stream FIFOs between dataflow processes (e.g. PE_i4xi4 pack stages). It wraps an SRL-inferable delay line with its own pointer and full/empty control, so it forms a complete FIFO rather than a bare shift register. It adds an occupancy count, a programmable almost-full flag, clock-enable qualified handshakes and an optional registered-output mode for timing closure on long PE chains.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
ADDR_WIDTH, 4, SRL address width; DEPTH <= 2**ADDR_WIDTH
DEPTH, 16, SRL entries (>=2)
OUT_REG, 0, 0 = combinational show-ahead output; 1 = registered first-word-fall-through output stage
AF_MARGIN, 2, almost_full_n deasserts when free slots <= AF_MARGIN (0..CAP-1)
CAP (derived, not overridable), DEPTH+OUT_REG, total capacity

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_write_ce  in  1  write-side clock enable
if_write  in  1  write request
if_din  in  DATA_WIDTH  write data
if_full_n  out  1  1 = space available
if_almost_full_n  out  1  0 = free slots <= AF_MARGIN
if_read_ce  in  1  read-side clock enable
if_read  in  1  read request (pop)
if_dout  out  DATA_WIDTH  head data, valid while if_empty_n=1
if_empty_n  out  1  1 = head valid
count  out  ADDR_WIDTH+1  occupied entries, 0..CAP

Behaviour:
- push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n. A request with the flag low is ignored; no error state.
- Reset (async assert, sync-safe deassert at next edge): count=0, if_full_n=1, if_almost_full_n=1, if_empty_n=0, SRL pointer=0. OUT_REG=1: output register and its valid bit =0, so if_dout=0. SRL contents are not reset, which keeps them SRL-inferable. OUT_REG=0: if_dout is don't-care while if_empty_n=0. Reset mid-operation discards all entries.
- SRL: on an SRL write, all entries shift by one and din enters slot 0. Head read address = srl_cnt-1.
- OUT_REG=0:
  - if_dout = SRL[srl_cnt-1] (combinational).
  - if_empty_n registered, = (next count != 0).
  - Write to empty FIFO -> if_empty_n=1 and if_dout=din on the next cycle (latency 1).
- OUT_REG=1:
  - The output register loads SRL head when (out_valid=0 or pop) and srl_cnt>0.
  - if_empty_n = out_valid; if_dout = output register.
  - Write to empty FIFO -> if_empty_n=1 two cycles later.
  - On simultaneous pop and empty SRL, out_valid clears.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It is updated at the same edge as the flags, and in OUT_REG=1 it includes the output register.
- if_full_n registered = (next count != CAP).
- if_almost_full_n registered = (CAP - next count > AF_MARGIN).
- Simultaneous push and pop:
  - Full: full_n=0 blocks the push; the pop proceeds; next cycle full_n=1.
  - Empty: empty_n=0 blocks the pop; the push proceeds. No write-through bypass in either mode.
  - Otherwise: both proceed, count holds, and order is preserved (strict FIFO).
- CE low on a side freezes that side only; the other side operates normally.
- No X on any flag or on count after reset.

Test Plan:
1. Reset then fill (DEPTH=16, OUT_REG=0): 16 pushes of 0x0..0xF -> count=16, if_full_n=0 after the 16th edge, if_almost_full_n=0 from count=14. A 17th push is ignored, count stays 16.
2. Drain: 16 pops -> if_dout sequence 0x0..0xF in order, if_empty_n=0 after the last pop, count=0. A further pop is ignored.
3. Latency: push 0xA5 into empty FIFO -> OUT_REG=0: if_empty_n=1 and if_dout=0xA5 one cycle later. OUT_REG=1: same values two cycles later. Repeat with CAP=17: 17 pushes are accepted.
4. Simultaneous push+pop at count=5 for 20 cycles with an incrementing pattern -> count stays 5 and output data equals input delayed by 5 entries. At full: push+pop -> pop accepted, push rejected, count=CAP-1.
5. CE gating: if_read_ce=0 with if_read=1 for 4 cycles while pushing -> no pops and count rises by 4. if_write_ce=0 -> pushes ignored.
6. Async reset mid-stream at count=9: assert reset_n=0 between edges -> flags and count take reset values immediately without a clock edge. A push after release returns that new word first.

Source files
------------

// File: rtl/srl_fifo_fwft_gen2.sv
// srl_fifo_fwft_gen2
//   First-word-fall-through FIFO built on an SRL-style delay line. The design
//   adds an occupancy count, a programmable almost-full flag and clock-enable
//   qualified handshakes. An optional registered output stage can be enabled
//   for timing.
//
// Handshake semantics (both sides):
//   push = if_write & if_write_ce & if_full_n
//   pop  = if_read  & if_read_ce  & if_empty_n
//   A request made while its flag is low is dropped silently. There is no
//   error state. When a side's CE is low, that side is frozen and the other
//   side keeps working.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   if_write_ce/if_write  write-side enable / request, if_din write data
//   if_full_n             1 = space available (registered)
//   if_almost_full_n      0 = free slots <= AF_MARGIN (registered)
//   if_read_ce/if_read    read-side enable / pop request
//   if_dout, if_empty_n   head data, valid while if_empty_n = 1
//   count                 occupied entries 0..CAP; includes the output
//                         register when OUT_REG = 1
module srl_fifo_fwft_gen2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 0,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP    = CW'(DEPTH + OUT_REG);
  localparam logic [CW-1:0] AF_LIM = CW'(AF_MARGIN);

  // The delay line has no reset, so synthesis can map it onto SRL primitives.
  logic [DATA_WIDTH-1:0] srl [DEPTH];

  logic [CW-1:0]         srl_cnt;
  logic [CW-1:0]         srl_cnt_next;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] srl_head;
  logic                  full_n_q;
  logic                  af_n_q;
  logic                  push;
  logic                  pop;
  logic                  srl_rd;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & if_empty_n;

  // Newest word sits in slot 0, so the oldest word is at srl_cnt-1.
  assign rd_addr  = ADDR_WIDTH'(srl_cnt - CW'(1));
  assign srl_head = srl[rd_addr];

  assign srl_cnt_next = srl_cnt + CW'(push) - CW'(srl_rd);
  assign count_next   = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srl_cnt  <= '0;
      count_q  <= '0;
      full_n_q <= 1'b1;
      af_n_q   <= 1'b1;
    end else begin
      srl_cnt  <= srl_cnt_next;
      count_q  <= count_next;
      full_n_q <= (count_next != CAP);
      af_n_q   <= ((CAP - count_next) > AF_LIM);
    end
  end

  assign if_full_n        = full_n_q;
  assign if_almost_full_n = af_n_q;
  assign count            = count_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  load;

    // Refill the output register whenever it is empty or being consumed.
    // A word pushed into an empty FIFO is never bypassed straight into it,
    // so it takes one extra cycle to reach the output.
    assign load = (!out_valid || pop) && (srl_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_data  <= srl_head;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end

    assign srl_rd     = load;
    assign if_dout    = out_data;
    assign if_empty_n = out_valid;
  end else begin : g_show_ahead
    logic empty_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        empty_n_q <= 1'b0;
      end else begin
        empty_n_q <= (count_next != '0);
      end
    end

    assign srl_rd     = pop;
    assign if_dout    = srl_head;
    assign if_empty_n = empty_n_q;
  end

endmodule

// File: tb/tb_srl_fifo_fwft_gen2.sv
// Bench for srl_fifo_fwft_gen2. It runs two instances, OUT_REG = 0 (CAP 16)
// and OUT_REG = 1 (CAP 17), with the same stimulus on both. Each instance
// has its own queue model.
module tb_srl_fifo_fwft_gen2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr, wce, rd, rce;
  logic [31:0] din;

  logic        full0, af0, empty0, full1, af1, empty1;
  logic [31:0] dout0, dout1;
  logic [4:0]  cnt0, cnt1;

  srl_fifo_fwft_gen2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .OUT_REG(0), .AF_MARGIN(2)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_full_n(full0), .if_almost_full_n(af0), .if_read_ce(rce), .if_read(rd),
    .if_dout(dout0), .if_empty_n(empty0), .count(cnt0)
  );

  srl_fifo_fwft_gen2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .OUT_REG(1), .AF_MARGIN(2)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_full_n(full1), .if_almost_full_n(af1), .if_read_ce(rce), .if_read(rd),
    .if_dout(dout1), .if_empty_n(empty1), .count(cnt1)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each model is a plain FIFO of words. Each word carries the index of the
  // edge that pushed it. The head word is visible once it is at least m edges
  // old, where m is 0 for show-ahead and 1 for the registered output.
  logic [31:0] mdata  [2][64];
  int          mstamp [2][64];
  int          mhead  [2];
  int          msize  [2];
  int          edge_n = 0;

  initial begin
    mhead[0] = 0; mhead[1] = 0; msize[0] = 0; msize[1] = 0;
  end

  function automatic int mcap(input int m);
    return 16 + m;
  endfunction

  function automatic bit m_full_n(input int m);
    return msize[m] != mcap(m);
  endfunction

  function automatic bit m_af_n(input int m);
    return (mcap(m) - msize[m]) > 2;
  endfunction

  function automatic bit m_empty_n(input int m);
    return (msize[m] > 0) && ((edge_n - mstamp[m][mhead[m]]) >= m);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    bit push_m [2];
    bit pop_m  [2];
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        msize[m] = 0;
        mhead[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        push_m[m] = wr && wce && m_full_n(m);
        pop_m[m]  = rd && rce && m_empty_n(m);
      end
      edge_n++;
      for (int m = 0; m < 2; m++) begin
        if (pop_m[m]) begin
          mhead[m] = (mhead[m] + 1) % 64;
          msize[m] = msize[m] - 1;
        end
        if (push_m[m]) begin
          mdata[m][(mhead[m] + msize[m]) % 64]  = din;
          mstamp[m][(mhead[m] + msize[m]) % 64] = edge_n;
          msize[m] = msize[m] + 1;
        end
      end
    end
  end

  task automatic cmp(input int m, input logic [4:0] c, input logic f, input logic a,
                     input logic e, input logic [31:0] d);
    chk($sformatf("m%0d_count", m), 32'(c), 32'(msize[m]));
    chk($sformatf("m%0d_full_n", m), 32'(f), 32'(m_full_n(m)));
    chk($sformatf("m%0d_af_n", m), 32'(a), 32'(m_af_n(m)));
    chk($sformatf("m%0d_empty_n", m), 32'(e), 32'(m_empty_n(m)));
    if (m_empty_n(m)) chk($sformatf("m%0d_dout", m), d, mdata[m][mhead[m]]);
  endtask

  always @(posedge clk) begin
    #1;
    cmp(0, cnt0, full0, af0, empty0, dout0);
    cmp(1, cnt1, full1, af1, empty1, dout1);
  end

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic we, input logic [31:0] d,
                      input logic r, input logic re);
    wr = w; wce = we; din = d; rd = r; rce = re;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic pop_one();
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    wr = 1'b0; wce = 1'b1; din = 32'h0; rd = 1'b0; rce = 1'b1;
    repeat (3) idle();
    chk("rst_count0", 32'(cnt0), 32'd0);
    chk("rst_full_n0", 32'(full0), 32'd1);
    chk("rst_af_n0", 32'(af0), 32'd1);
    chk("rst_empty_n0", 32'(empty0), 32'd0);
    chk("rst_count1", 32'(cnt1), 32'd0);
    chk("rst_empty_n1", 32'(empty1), 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    rst_n = 1'b1;
    idle();

    // fill with 0x0..0xF
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 32'(i), 1'b0, 1'b1);
      if (i == 12) chk("af_n_at_13", 32'(af0), 32'd1);
      if (i == 13) chk("af_n_at_14", 32'(af0), 32'd0);
    end
    chk("fill_count0", 32'(cnt0), 32'd16);
    chk("fill_full_n0", 32'(full0), 32'd0);
    chk("fill_af_n0", 32'(af0), 32'd0);
    chk("fill_full_n1", 32'(full1), 32'd1);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b1);
    chk("over_count0", 32'(cnt0), 32'd16);
    chk("over_count1", 32'(cnt1), 32'd17);
    chk("over_full_n1", 32'(full1), 32'd0);

    // drain in order
    for (int i = 0; i < 17; i++) begin
      if (i < 16) chk("drain_dout0", dout0, 32'(i));
      chk("drain_dout1", dout1, 32'(i));
      pop_one();
    end
    chk("drain_empty_n0", 32'(empty0), 32'd0);
    chk("drain_count0", 32'(cnt0), 32'd0);
    chk("drain_empty_n1", 32'(empty1), 32'd0);
    chk("drain_count1", 32'(cnt1), 32'd0);
    pop_one();
    chk("extra_pop_count0", 32'(cnt0), 32'd0);

    // write-to-read latency
    step(1'b1, 1'b1, 32'hA5, 1'b0, 1'b1);
    chk("lat1_empty_n0", 32'(empty0), 32'd1);
    chk("lat1_dout0", dout0, 32'hA5);
    chk("lat1_empty_n1", 32'(empty1), 32'd0);
    idle();
    chk("lat2_empty_n1", 32'(empty1), 32'd1);
    chk("lat2_dout1", dout1, 32'hA5);
    pop_one();

    // steady push+pop at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h101 + 32'(i), 1'b0, 1'b1);
    idle();
    for (int k = 0; k < 20; k++) begin
      chk("steady_dout0", dout0, 32'h101 + 32'(k));
      chk("steady_dout1", dout1, 32'h101 + 32'(k));
      step(1'b1, 1'b1, 32'h106 + 32'(k), 1'b1, 1'b1);
    end
    chk("steady_count0", 32'(cnt0), 32'd5);
    chk("steady_count1", 32'(cnt1), 32'd5);
    repeat (6) pop_one();
    chk("steady_drain_count1", 32'(cnt1), 32'd0);

    // push+pop while full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'h300 + 32'(i), 1'b0, 1'b1);
    chk("full_head0", dout0, 32'h300);
    step(1'b1, 1'b1, 32'h3FF, 1'b1, 1'b1);
    chk("full_pp_count0", 32'(cnt0), 32'd15);
    chk("full_pp_full_n0", 32'(full0), 32'd1);
    chk("full_pp_dout0", dout0, 32'h301);
    chk("full_pp_count1", 32'(cnt1), 32'd16);
    repeat (18) pop_one();
    chk("full_drain_count0", 32'(cnt0), 32'd0);
    chk("full_drain_count1", 32'(cnt1), 32'd0);

    // clock-enable gating
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h400 + 32'(i), 1'b1, 1'b0);
    chk("ce_rd_count0", 32'(cnt0), 32'd4);
    chk("ce_rd_count1", 32'(cnt1), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h4F0, 1'b0, 1'b1);
    chk("ce_wr_count0", 32'(cnt0), 32'd4);
    step(1'b1, 1'b0, 32'h4F1, 1'b1, 1'b1);
    chk("ce_wr_pop_count0", 32'(cnt0), 32'd3);
    chk("ce_wr_pop_count1", 32'(cnt1), 32'd3);
    repeat (6) pop_one();

    // asynchronous reset mid-stream
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 32'h500 + 32'(i), 1'b0, 1'b1);
    chk("pre_rst_count0", 32'(cnt0), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count0", 32'(cnt0), 32'd0);
    chk("arst_full_n0", 32'(full0), 32'd1);
    chk("arst_af_n0", 32'(af0), 32'd1);
    chk("arst_empty_n0", 32'(empty0), 32'd0);
    chk("arst_count1", 32'(cnt1), 32'd0);
    chk("arst_empty_n1", 32'(empty1), 32'd0);
    chk("arst_dout1", dout1, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 1'b1, 32'h3C3, 1'b0, 1'b1);
    idle();
    chk("post_rst_dout0", dout0, 32'h3C3);
    chk("post_rst_dout1", dout1, 32'h3C3);
    chk("post_rst_count1", 32'(cnt1), 32'd1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
